// File: rtl/triple_decoder.sv
// Recovers roots a, b from a term set (x = a^2 - b^2, y = 2ab, z = a^2 + b^2)
// using two parallel restoring square-root engines, then re-checks the set.
module triple_decoder #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic [W-1:0]   in_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W/2-1:0] out_a,
  output logic [W/2-1:0] out_b,
  output logic           out_exact
);

  localparam int RW = W / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ROOT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [W-1:0]    rad_a_q, rad_a_d, rad_b_q, rad_b_d;
  logic [RW+1:0]   rem_a_q, rem_a_d, rem_b_q, rem_b_d;
  logic [RW-1:0]   root_a_q, root_a_d, root_b_q, root_b_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            odd_q, odd_d, neg_q, neg_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
  logic            out_exact_q, out_exact_d;
  logic [W:0]      sum_s;
  logic [W-1:0]    prod_s;

  // One restoring step: bring down two radicand bits, try subtracting (4*root + 1).
  function automatic logic [2*RW+1:0] sqrt_step(input logic [RW+1:0] rem,
                                                input logic [RW-1:0] root,
                                                input logic [1:0]    pair);
    logic [RW+1:0] sh;
    logic [RW+1:0] trial;
    logic [2*RW+1:0] res;
    sh    = {rem[RW-1:0], pair};
    trial = {root, 2'b01};
    if (sh >= trial) begin
      res = {sh - trial, root[RW-2:0], 1'b1};
    end else begin
      res = {sh, root[RW-2:0], 1'b0};
    end
    return res;
  endfunction

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    rad_a_d     = rad_a_q;
    rad_b_d     = rad_b_q;
    rem_a_d     = rem_a_q;
    rem_b_d     = rem_b_q;
    root_a_d    = root_a_q;
    root_b_d    = root_b_q;
    cnt_d       = cnt_q;
    odd_d       = odd_q;
    neg_d       = neg_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_exact_d = out_exact_q;
    sum_s       = {1'b0, z_q} + {1'b0, x_q};
    prod_s      = {{RW{1'b0}}, root_a_q} * {{RW{1'b0}}, root_b_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = in_z;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        rad_a_d = sum_s[W:1];
        odd_d   = sum_s[0];
        if (z_q >= x_q) begin
          rad_b_d = (z_q - x_q) >> 1;
          neg_d   = 1'b0;
        end else begin
          rad_b_d = {W{1'b0}};
          neg_d   = 1'b1;
        end
        rem_a_d  = {(RW+2){1'b0}};
        rem_b_d  = {(RW+2){1'b0}};
        root_a_d = {RW{1'b0}};
        root_b_d = {RW{1'b0}};
        cnt_d    = 4'd15;
        state_d  = S_ROOT;
      end
      S_ROOT: begin
        {rem_a_d, root_a_d} = sqrt_step(rem_a_q, root_a_q, rad_a_q[W-1:W-2]);
        {rem_b_d, root_b_d} = sqrt_step(rem_b_q, root_b_q, rad_b_q[W-1:W-2]);
        rad_a_d = rad_a_q << 2;
        rad_b_d = rad_b_q << 2;
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        out_a_d = root_a_q;
        out_b_d = root_b_q;
        // A zero final remainder is exactly root*root == radicand.
        out_exact_d = !odd_q && !neg_q &&
                      (rem_a_q == {(RW+2){1'b0}}) && (rem_b_q == {(RW+2){1'b0}}) &&
                      ({prod_s[W-2:0], 1'b0} == y_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= {W{1'b0}};
      y_q         <= {W{1'b0}};
      z_q         <= {W{1'b0}};
      rad_a_q     <= {W{1'b0}};
      rad_b_q     <= {W{1'b0}};
      rem_a_q     <= {(RW+2){1'b0}};
      rem_b_q     <= {(RW+2){1'b0}};
      root_a_q    <= {RW{1'b0}};
      root_b_q    <= {RW{1'b0}};
      cnt_q       <= 4'd0;
      odd_q       <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_a_q     <= {RW{1'b0}};
      out_b_q     <= {RW{1'b0}};
      out_exact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      rad_a_q     <= rad_a_d;
      rad_b_q     <= rad_b_d;
      rem_a_q     <= rem_a_d;
      rem_b_q     <= rem_b_d;
      root_a_q    <= root_a_d;
      root_b_q    <= root_b_d;
      cnt_q       <= cnt_d;
      odd_q       <= odd_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_exact_q <= out_exact_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_exact = out_exact_q;

endmodule
